// File: rtl/lc4_alu_exec.sv
// LC4 execute-stage ALU: single-cycle ops are registered with one cycle of latency;
// MUL/DIV/MOD iterate on a shared shift datapath behind a valid/ready handshake.
module lc4_alu_exec #(
    parameter int unsigned BITS_PER_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_alu_ctl,
    input  logic [15:0] i_insn,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_rs_data,
    input  logic [15:0] i_rt_data,
    output logic        o_valid,
    output logic [15:0] o_result,
    output logic        o_illegal
);

    localparam int unsigned ITERS = 16 / BITS_PER_CYC;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] K_MUL = 2'd0;
    localparam logic [1:0] K_DIV = 2'd1;
    localparam logic [1:0] K_MOD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  kind_q, kind_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic        dz_q, dz_d;
    logic        valid_q, valid_d;
    logic [15:0] result_q, result_d;
    logic        illegal_q, illegal_d;

    logic        issue;
    logic        is_multi;
    logic [15:0] imm5, imm6, imm7, uimm7, imm9, imm11, uimm4, uimm8;
    logic [15:0] sc_result;
    logic        sc_illegal;
    logic [15:0] it_a, it_b, it_acc;
    logic [16:0] trial;
    logic [15:0] final_result;
    logic        unused_insn_hi;

    assign unused_insn_hi = ^i_insn[15:11];

    assign imm5  = {{11{i_insn[4]}}, i_insn[4:0]};
    assign imm6  = {{10{i_insn[5]}}, i_insn[5:0]};
    assign imm7  = {{9{i_insn[6]}}, i_insn[6:0]};
    assign uimm7 = {9'd0, i_insn[6:0]};
    assign imm9  = {{7{i_insn[8]}}, i_insn[8:0]};
    assign imm11 = {{5{i_insn[10]}}, i_insn[10:0]};
    assign uimm4 = {12'd0, i_insn[3:0]};
    assign uimm8 = {8'd0, i_insn[7:0]};

    function automatic logic [15:0] cmp_res(input logic lt, input logic eq);
        if (lt)      return 16'hFFFF;
        else if (eq) return 16'h0000;
        else         return 16'h0001;
    endfunction

    assign o_ready  = (state_q != S_BUSY);
    assign issue    = i_valid & o_ready;
    assign is_multi = (i_alu_ctl == 16'd1) || (i_alu_ctl == 16'd3) || (i_alu_ctl == 16'd4);

    always_comb begin
        sc_result  = '0;
        sc_illegal = 1'b0;
        case (i_alu_ctl)
            16'd0:  sc_result = i_rs_data + i_rt_data;
            16'd2:  sc_result = i_rs_data - i_rt_data;
            16'd5:  sc_result = i_rs_data + imm5;
            16'd6:  sc_result = i_rs_data + imm6;
            16'd8:  sc_result = i_rs_data & i_rt_data;
            16'd9:  sc_result = ~i_rs_data;
            16'd10: sc_result = i_rs_data | i_rt_data;
            16'd11: sc_result = i_rs_data ^ i_rt_data;
            16'd12: sc_result = i_rs_data & imm5;
            16'd16: sc_result = cmp_res($signed(i_rs_data) < $signed(i_rt_data), i_rs_data == i_rt_data);
            16'd17: sc_result = cmp_res(i_rs_data < i_rt_data, i_rs_data == i_rt_data);
            16'd18: sc_result = cmp_res($signed(i_rs_data) < $signed(imm7), i_rs_data == imm7);
            16'd19: sc_result = cmp_res(i_rs_data < uimm7, i_rs_data == uimm7);
            16'd24: sc_result = i_rs_data << uimm4;
            16'd25: sc_result = $unsigned($signed(i_rs_data) >>> uimm4);
            16'd26: sc_result = i_rs_data >> uimm4;
            16'd32: sc_result = imm9;
            16'd33: sc_result = (i_rs_data & 16'h00FF) | (uimm8 << 8);
            16'd34: sc_result = i_rs_data;
            16'd35: sc_result = i_pc + 16'd1 + imm11;
            16'd36: sc_result = i_rs_data;
            16'd37: sc_result = 16'h8000 | uimm8;
            16'd1, 16'd3, 16'd4: sc_result = '0;
            default: sc_illegal = 1'b1;
        endcase
    end

    // MUL: a = shifted multiplicand, b = multiplier consumed LSB-first.
    // DIV/MOD: a = divisor, b = dividend shifting out MSB-first while quotient bits shift in.
    always_comb begin
        it_a   = a_q;
        it_b   = b_q;
        it_acc = acc_q;
        trial  = '0;
        for (int unsigned j = 0; j < BITS_PER_CYC; j++) begin
            if (kind_q == K_MUL) begin
                if (it_b[0]) it_acc = it_acc + it_a;
                it_a = it_a << 1;
                it_b = it_b >> 1;
            end else begin
                trial = {it_acc, it_b[15]};
                it_b  = {it_b[14:0], 1'b0};
                if (trial >= {1'b0, it_a}) begin
                    trial   = trial - {1'b0, it_a};
                    it_b[0] = 1'b1;
                end
                it_acc = trial[15:0];
            end
        end
    end

    always_comb begin
        final_result = '0;
        case (kind_q)
            K_MUL:   final_result = it_acc;
            K_DIV:   final_result = dz_q ? 16'h0000 : it_b;
            K_MOD:   final_result = dz_q ? 16'h0000 : it_acc;
            default: final_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        dz_d      = dz_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        illegal_d = illegal_q;
        if (state_q == S_BUSY) begin
            a_d   = it_a;
            b_d   = it_b;
            acc_d = it_acc;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                state_d   = S_DONE;
                valid_d   = 1'b1;
                result_d  = final_result;
                illegal_d = 1'b0;
            end
        end else begin
            state_d = S_IDLE;
            if (issue) begin
                if (is_multi) begin
                    state_d = S_BUSY;
                    cnt_d   = 5'(ITERS);
                    acc_d   = '0;
                    dz_d    = (i_rt_data == 16'd0);
                    if (i_alu_ctl == 16'd1) begin
                        kind_d = K_MUL;
                        a_d    = i_rs_data;
                        b_d    = i_rt_data;
                    end else begin
                        kind_d = (i_alu_ctl == 16'd3) ? K_DIV : K_MOD;
                        a_d    = i_rt_data;
                        b_d    = i_rs_data;
                    end
                end else begin
                    valid_d   = 1'b1;
                    result_d  = sc_result;
                    illegal_d = sc_illegal;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            kind_q    <= K_MUL;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            dz_q      <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            dz_q      <= dz_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_result  = result_q;
    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_lc4_alu_exec.sv
// Scoreboard bench for lc4_alu_exec: the driver queues hand-computed results with their
// expected arrival cycle, and a monitor checks each o_valid pulse against the queue head.
module tb_lc4_alu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_alu_ctl, i_insn, i_pc, i_rs_data, i_rt_data;
    logic        o_valid;
    logic [15:0] o_result;
    logic        o_illegal;

    typedef struct {
        logic [15:0] res;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   w;

    lc4_alu_exec #(.BITS_PER_CYC(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_alu_ctl (i_alu_ctl),
        .i_insn    (i_insn),
        .i_pc      (i_pc),
        .i_rs_data (i_rs_data),
        .i_rt_data (i_rt_data),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_illegal (o_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got result %h with empty scoreboard (cycle %0d)", o_result, cyc);
            end else begin
                e = sb.pop_front();
                check("result", o_result, e.res);
                check("illegal", {15'd0, o_illegal}, {15'd0, e.ill});
                check("latency_cycle", 16'(cyc), 16'(e.cyc));
            end
        end
    end

    // Presents an op, waits (bounded) for o_ready, and schedules its expected response.
    task automatic issue(input logic [15:0] ctl, input logic [15:0] insn, input logic [15:0] pc,
                         input logic [15:0] rs, input logic [15:0] rt,
                         input logic [15:0] exp_res, input logic exp_ill, input int lat,
                         input bit push, output int waited);
        exp_t e;
        waited    = 0;
        i_valid   = 1'b1;
        i_alu_ctl = ctl;
        i_insn    = insn;
        i_pc      = pc;
        i_rs_data = rs;
        i_rt_data = rt;
        @(negedge clk);
        while (o_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got o_ready=%b expected 1 within 100 cycles", o_ready);
        end else if (push) begin
            e.res = exp_res;
            e.ill = exp_ill;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_alu_ctl = '0;
        i_insn    = '0;
        i_pc      = '0;
        i_rs_data = '0;
        i_rt_data = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", {15'd0, o_ready}, 16'd1);
        check("rst_valid", {15'd0, o_valid}, 16'd0);
        check("rst_result", o_result, 16'h0000);
        check("rst_illegal", {15'd0, o_illegal}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // overflow wraps
        issue(16'd0, 16'h0000, 16'h0000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1, 1'b1, w);

        // divide with busy window; inputs toggled during BUSY must be ignored
        issue(16'd3, 16'h0000, 16'h0000, 16'd100, 16'd7, 16'd14, 1'b0, 17, 1'b1, w);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("busy_ready", {15'd0, o_ready}, 16'd0);
            i_valid   = (i < 15);
            i_alu_ctl = 16'd0;
            i_rs_data = 16'hDEAD;
            i_rt_data = 16'hBEEF;
            @(posedge clk);
            #1;
        end
        issue(16'd4, 16'h0000, 16'h0000, 16'd100, 16'd7, 16'd2, 1'b0, 17, 1'b1, w);
        check("done_accept_wait", 16'(w), 16'd0);

        issue(16'd3, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17, 1'b1, w);
        issue(16'd4, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17, 1'b1, w);
        issue(16'd3, 16'h0000, 16'h0000, 16'hFFFF, 16'h0010, 16'h0FFF, 1'b0, 17, 1'b1, w);
        issue(16'd4, 16'h0000, 16'h0000, 16'hFFFF, 16'h0010, 16'h000F, 1'b0, 17, 1'b1, w);
        issue(16'd1, 16'h0000, 16'h0000, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 17, 1'b1, w);
        issue(16'd1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17, 1'b1, w);

        issue(16'd16, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1, 1'b1, w);
        issue(16'd17, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1, 1'b1, w);
        issue(16'd19, 16'hFF05, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1, 1'b1, w);

        // reset during a multiply: its result must never appear
        issue(16'd1, 16'h0000, 16'h0000, 16'h0003, 16'h0003, 16'h0000, 1'b0, 17, 1'b0, w);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {15'd0, o_ready}, 16'd1);
        check("abort_result", o_result, 16'h0000);
        @(posedge clk);
        #1;
        issue(16'd25, 16'h000F, 16'h0000, 16'h8000, 16'h0000, 16'hFFFF, 1'b0, 1, 1'b1, w);

        issue(16'd7, 16'h0000, 16'h0000, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1, 1'b1, w);

        // back-to-back single-cycle ops
        issue(16'd2,  16'h0000, 16'h0000, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1, 1'b1, w);
        issue(16'd5,  16'h001F, 16'h0000, 16'h0010, 16'h0000, 16'h000F, 1'b0, 1, 1'b1, w);
        issue(16'd6,  16'h0020, 16'h0000, 16'h0100, 16'h0000, 16'h00E0, 1'b0, 1, 1'b1, w);
        issue(16'd8,  16'h0000, 16'h0000, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1, 1'b1, w);
        issue(16'd9,  16'h0000, 16'h0000, 16'h1234, 16'h0000, 16'hEDCB, 1'b0, 1, 1'b1, w);
        issue(16'd10, 16'h0000, 16'h0000, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1, 1'b1, w);
        issue(16'd11, 16'h0000, 16'h0000, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, 1, 1'b1, w);
        issue(16'd12, 16'h0010, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFF0, 1'b0, 1, 1'b1, w);
        issue(16'd18, 16'h007F, 16'h0000, 16'h0003, 16'h0000, 16'h0001, 1'b0, 1, 1'b1, w);
        issue(16'd24, 16'h0004, 16'h0000, 16'h0001, 16'h0000, 16'h0010, 1'b0, 1, 1'b1, w);
        issue(16'd26, 16'h000F, 16'h0000, 16'h8000, 16'h0000, 16'h0001, 1'b0, 1, 1'b1, w);
        issue(16'd32, 16'h01FF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1, 1'b1, w);
        issue(16'd33, 16'h00CD, 16'h0000, 16'h12AB, 16'h0000, 16'hCDAB, 1'b0, 1, 1'b1, w);
        issue(16'd34, 16'h0000, 16'h0000, 16'hBEEF, 16'h1111, 16'hBEEF, 1'b0, 1, 1'b1, w);
        issue(16'd35, 16'h07FF, 16'h1000, 16'h0000, 16'h0000, 16'h1000, 1'b0, 1, 1'b1, w);
        issue(16'd36, 16'h0000, 16'h0000, 16'hCAFE, 16'h2222, 16'hCAFE, 1'b0, 1, 1'b1, w);
        issue(16'd37, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 16'h8042, 1'b0, 1, 1'b1, w);
        issue(16'd40, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1, 1'b1, w);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d outstanding responses expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
